// File: rtl/rriot_pkg.sv
// rriot_pkg
// Shared types and address-map constants for the RRIOT bus sequencer.
//   tgt_e        : decoded target of one bus cycle
//   bus_state_e  : bus sequencer FSM states
//   decode_tgt   : priority decode of cs_n / rs / bus_a to a target
//   remap_addr   : CPU address to the selected block's local address
package rriot_pkg;

   typedef enum logic [2:0] {
      TGT_NONE,
      TGT_ROM,
      TGT_RAM,
      TGT_IO,
      TGT_TIMER
   } tgt_e;

   typedef enum logic [2:0] {
      IDLE,
      SETUP,
      STROBE,
      WAIT,
      HOLD
   } bus_state_e;

   localparam int RAM_SEL_BIT = 6;  // 0 selects RAM when not ROM space
   localparam int TMR_SEL_BIT = 2;  // 0 selects IO, 1 selects timer
   localparam int TMR_IRQ_BIT = 3;  // CPU A3 becomes timer local A2 (irq enable)

   // Priority: chip select, then ROM space, then RAM, then IO, else timer.
   function automatic tgt_e decode_tgt(input logic cs_n, input logic rs,
                                       input logic [9:0] a);
      tgt_e t;
      if (cs_n)                  t = TGT_NONE;
      else if (rs)               t = TGT_ROM;
      else if (!a[RAM_SEL_BIT])  t = TGT_RAM;
      else if (!a[TMR_SEL_BIT])  t = TGT_IO;
      else                       t = TGT_TIMER;
      return t;
   endfunction

   // A miss keeps the raw address; no enable fires so its value is unused.
   function automatic logic [9:0] remap_addr(input tgt_e t, input logic [9:0] a);
      logic [9:0] r;
      case (t)
         TGT_ROM:   r = a;
         TGT_RAM:   r = {4'b0, a[5:0]};
         TGT_IO:    r = {8'b0, a[1:0]};
         TGT_TIMER: r = {7'b0, a[TMR_IRQ_BIT], a[1:0]};
         default:   r = a;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/rriot_bus_ctrl_phi2_sync.sv
// phi2_sync
// Brings the asynchronous 6502 phi2 clock into the clk domain with a
// two-flop synchroniser, then compares against one more register to form
// single-clk rise and fall pulses.
//   clk, rst_n : core clock, async active-low reset
//   phi2       : raw phase-2 clock
//   rise, fall : one-clk pulses on synchronised phi2 edges
module phi2_sync (
   input  logic clk,
   input  logic rst_n,
   input  logic phi2,
   output logic rise,
   output logic fall
);

   logic s1_q;
   logic s2_q;
   logic prev_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_q   <= 1'b0;
         s2_q   <= 1'b0;
         prev_q <= 1'b0;
      end else begin
         s1_q   <= phi2;
         s2_q   <= s1_q;
         prev_q <= s2_q;
      end
   end

   assign rise = s2_q & ~prev_q;
   assign fall = ~s2_q & prev_q;

endmodule

// File: rtl/rriot_bus_ctrl.sv
// rriot_bus_ctrl
// Bus-side sequencer for the RRIOT cluster (ROM, RAM, IO port, timer).
// Each phi2-high period becomes at most one single-clk enable strobe to the
// decoded sub-block; read data is captured and held on cpu_do with cpu_oe
// until phi2 falls.
//   clk, rst_n          : core clock, async active-low reset
//   phi2, cs_n, rs      : CPU-side clock, chip select, ROM select
//   bus_a, bus_rw, bus_di : CPU address, read(1)/write(0), write data
//   cpu_do, cpu_oe      : read data to CPU and its drive enable
//   sub_we_n, sub_a, sub_di : latched write qualifier, local address, data
//   rom_en .. timer_en  : one-clk enables, at most one high
//   rom_do .. timer_do  : sub-block read data
//   dbg_state           : current sequencer state
//
// Handshake: a sub-block is selected only in the single STROBE clk when its
// *_en is high; it must present read data on *_do within RD_LAT clks, when
// it is sampled once. There is no back-pressure.
module rriot_bus_ctrl
   import rriot_pkg::*;
#(
   parameter int SETUP_CYC = 2,
   parameter int RD_LAT    = 1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       phi2,
   input  logic       cs_n,
   input  logic       rs,
   input  logic [9:0] bus_a,
   input  logic       bus_rw,
   input  logic [7:0] bus_di,
   output logic [7:0] cpu_do,
   output logic       cpu_oe,
   output logic       sub_we_n,
   output logic [9:0] sub_a,
   output logic [7:0] sub_di,
   output logic       rom_en,
   output logic       ram_en,
   output logic       io_en,
   output logic       timer_en,
   input  logic [7:0] rom_do,
   input  logic [7:0] ram_do,
   input  logic [7:0] io_do,
   input  logic [7:0] timer_do,
   output bus_state_e dbg_state
);

   localparam logic [3:0] SETUP_LD  = 4'(SETUP_CYC);
   localparam logic [3:0] RD_LAT_M1 = 4'(RD_LAT - 1);

   logic       rise;
   logic       fall;

   bus_state_e state_q, state_d;
   logic [3:0] cnt_q, cnt_d;
   logic       fall_seen_q, fall_seen_d;
   tgt_e       tgt_q;
   tgt_e       tgt_dec;

   logic       latch_en;
   logic       capture_en;
   logic       oe_set;
   logic       oe_clr;
   logic [7:0] rd_mux;

   phi2_sync u_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .phi2  (phi2),
      .rise  (rise),
      .fall  (fall)
   );

   assign tgt_dec = decode_tgt(cs_n, rs, bus_a);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         cnt_q       <= 4'd0;
         fall_seen_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         fall_seen_q <= fall_seen_d;
      end
   end

   // A fall seen during STROBE/WAIT is remembered so the cycle still
   // completes its capture but never drives the CPU bus afterwards.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      fall_seen_d = fall_seen_q;
      latch_en    = 1'b0;
      capture_en  = 1'b0;
      oe_set      = 1'b0;
      oe_clr      = 1'b0;
      case (state_q)
         IDLE: begin
            fall_seen_d = 1'b0;
            if (rise) begin
               cnt_d   = SETUP_LD;
               state_d = SETUP;
            end
         end
         SETUP: begin
            if (fall) begin
               state_d = IDLE;
            end else if (cnt_q == 4'd0) begin
               latch_en = 1'b1;
               state_d  = STROBE;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         STROBE: begin
            if (fall) fall_seen_d = 1'b1;
            if (tgt_q != TGT_NONE && sub_we_n) begin
               cnt_d   = RD_LAT_M1;
               state_d = WAIT;
            end else begin
               state_d = HOLD;
            end
         end
         WAIT: begin
            if (fall) fall_seen_d = 1'b1;
            if (cnt_q == 4'd0) begin
               capture_en = 1'b1;
               if (fall || fall_seen_q) begin
                  state_d = IDLE;
               end else begin
                  oe_set  = 1'b1;
                  state_d = HOLD;
               end
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         HOLD: begin
            if (fall || fall_seen_q) begin
               oe_clr  = 1'b1;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      rd_mux = 8'h00;
      case (tgt_q)
         TGT_ROM:   rd_mux = rom_do;
         TGT_RAM:   rd_mux = ram_do;
         TGT_IO:    rd_mux = io_do;
         TGT_TIMER: rd_mux = timer_do;
         default:   rd_mux = 8'h00;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tgt_q    <= TGT_NONE;
         sub_a    <= 10'd0;
         sub_di   <= 8'd0;
         sub_we_n <= 1'b1;
         cpu_do   <= 8'd0;
         cpu_oe   <= 1'b0;
      end else begin
         if (latch_en) begin
            tgt_q    <= tgt_dec;
            sub_a    <= remap_addr(tgt_dec, bus_a);
            sub_di   <= bus_di;
            sub_we_n <= bus_rw;
         end
         if (capture_en) cpu_do <= rd_mux;
         if (oe_set)      cpu_oe <= 1'b1;
         else if (oe_clr) cpu_oe <= 1'b0;
      end
   end

   // Enables are a pure decode of the STROBE state, so they clear the
   // instant reset forces IDLE.
   assign rom_en    = (state_q == STROBE) && (tgt_q == TGT_ROM);
   assign ram_en    = (state_q == STROBE) && (tgt_q == TGT_RAM);
   assign io_en     = (state_q == STROBE) && (tgt_q == TGT_IO);
   assign timer_en  = (state_q == STROBE) && (tgt_q == TGT_TIMER);
   assign dbg_state = state_q;

endmodule

// File: tb/tb_rriot_bus_ctrl.sv
// tb_rriot_bus_ctrl
// Drives CPU bus cycles into rriot_bus_ctrl and checks strobe timing,
// address remap, read capture and cpu_oe framing. Sub-blocks are modelled
// as constant read-data sources.
module tb_rriot_bus_ctrl;
   import rriot_pkg::*;

   localparam int TB_SETUP = 4;
   localparam int TB_RDLAT = 2;
   // phi2 is raised at a negedge and first sampled by the next posedge;
   // the strobe begins TB_SETUP+3 posedges after that one, so it is seen
   // at sample index TB_SETUP+4 counted in negedges from the raise.
   localparam int STB_IDX  = TB_SETUP + 4;
   localparam int OE_IDX   = STB_IDX + TB_RDLAT + 1;

   localparam logic [7:0] ROM_D = 8'h5A;
   localparam logic [7:0] RAM_D = 8'hA5;
   localparam logic [7:0] IO_D  = 8'h3C;
   localparam logic [7:0] TMR_D = 8'hC3;

   logic       clk;
   logic       rst_n;
   logic       phi2;
   logic       cs_n;
   logic       rs;
   logic [9:0] bus_a;
   logic       bus_rw;
   logic [7:0] bus_di;
   logic [7:0] cpu_do;
   logic       cpu_oe;
   logic       sub_we_n;
   logic [9:0] sub_a;
   logic [7:0] sub_di;
   logic       rom_en, ram_en, io_en, timer_en;
   logic [7:0] rom_do, ram_do, io_do, timer_do;
   bus_state_e dbg_state;

   int checks = 0;
   int errors = 0;

   // strobe record: {rom,ram,io,timer enables, sub_we_n, sub_a, sub_di}
   logic [22:0] exp_q[$];
   logic [7:0]  rd_q[$];
   logic        prev_oe = 1'b0;

   rriot_bus_ctrl #(.SETUP_CYC(TB_SETUP), .RD_LAT(TB_RDLAT)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .phi2      (phi2),
      .cs_n      (cs_n),
      .rs        (rs),
      .bus_a     (bus_a),
      .bus_rw    (bus_rw),
      .bus_di    (bus_di),
      .cpu_do    (cpu_do),
      .cpu_oe    (cpu_oe),
      .sub_we_n  (sub_we_n),
      .sub_a     (sub_a),
      .sub_di    (sub_di),
      .rom_en    (rom_en),
      .ram_en    (ram_en),
      .io_en     (io_en),
      .timer_en  (timer_en),
      .rom_do    (rom_do),
      .ram_do    (ram_do),
      .io_do     (io_do),
      .timer_do  (timer_do),
      .dbg_state (dbg_state)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // scoreboard monitor
   always @(negedge clk) begin
      logic [3:0]  en_vec;
      logic [22:0] got;
      logic [22:0] exp;
      logic [7:0]  exp_d;
      if (rst_n) begin
         en_vec = {rom_en, ram_en, io_en, timer_en};
         if (en_vec != 4'b0) begin
            checks++;
            got = {en_vec, sub_we_n, sub_a, sub_di};
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL strobe_unexpected: got %h, required no strobe", got);
            end else begin
               exp = exp_q.pop_front();
               if (got !== exp) begin
                  errors++;
                  $display("FAIL strobe: got %h, required %h", got, exp);
               end
            end
         end
         if (cpu_oe && !prev_oe) begin
            checks++;
            if (rd_q.size() == 0) begin
               errors++;
               $display("FAIL oe_unexpected: cpu_do %h with no read pending", cpu_do);
            end else begin
               exp_d = rd_q.pop_front();
               if (cpu_do !== exp_d) begin
                  errors++;
                  $display("FAIL read_data: got %h, required %h", cpu_do, exp_d);
               end
            end
         end
      end
      prev_oe = cpu_oe;
   end

   // driver: one phi2 pulse of high_clks clocks, observing enables and cpu_oe
   task automatic run_cycle(input logic c, input logic r, input logic [9:0] a,
                            input logic rw, input logic [7:0] di, input int high_clks,
                            output int en_cnt, output int en_idx,
                            output int oe_first, output int oe_last);
      int  idx;
      logic done;
      en_cnt = 0; en_idx = -1; oe_first = -1; oe_last = -1;
      done = 1'b0;
      @(negedge clk);
      cs_n = c; rs = r; bus_a = a; bus_rw = rw; bus_di = di; phi2 = 1'b1;
      idx = 0;
      for (int n = 0; n < 80; n++) begin
         @(negedge clk);
         idx++;
         if ({rom_en, ram_en, io_en, timer_en} != 4'b0) begin
            en_cnt++;
            en_idx = idx;
         end
         if (cpu_oe) begin
            if (oe_first < 0) oe_first = idx;
            oe_last = idx;
         end
         if (idx == high_clks) phi2 = 1'b0;
         if (idx > high_clks + 4 && dbg_state == IDLE) begin
            done = 1'b1;
            break;
         end
      end
      checks++;
      if (!done) begin
         errors++;
         $display("FAIL cycle_timeout: state %0d, required return to IDLE", dbg_state);
         phi2 = 1'b0;
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b1; phi2 = 1'b0; cs_n = 1'b1; rs = 1'b0;
      bus_a = 10'd0; bus_rw = 1'b1; bus_di = 8'd0;
      rom_do = ROM_D; ram_do = RAM_D; io_do = IO_D; timer_do = TMR_D;
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if ({rom_en, ram_en, io_en, timer_en} !== 4'b0) begin
         errors++;
         $display("FAIL reset_en: got %b, required 0000", {rom_en, ram_en, io_en, timer_en});
      end
      checks++;
      if ({cpu_oe, cpu_do} !== 9'd0) begin
         errors++;
         $display("FAIL reset_cpu: got oe %b do %h, required 0 00", cpu_oe, cpu_do);
      end
      checks++;
      if ({sub_we_n, sub_a, sub_di} !== {1'b1, 10'd0, 8'd0}) begin
         errors++;
         $display("FAIL reset_sub: got we_n %b a %h di %h, required 1 000 00",
                  sub_we_n, sub_a, sub_di);
      end
      checks++;
      if (dbg_state !== IDLE) begin
         errors++;
         $display("FAIL reset_state: got %0d, required IDLE", dbg_state);
      end
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_timer_write();
      int ec, ei, of, ol;
      exp_q.push_back({4'b0001, 1'b0, 10'h006, 8'h10});
      run_cycle(1'b0, 1'b0, 10'h04E, 1'b0, 8'h10, 8, ec, ei, of, ol);
      checks++;
      if (ec != 1 || ei != STB_IDX) begin
         errors++;
         $display("FAIL timer_wr_strobe: count %0d at %0d, required 1 at %0d", ec, ei, STB_IDX);
      end
      checks++;
      if (of != -1) begin
         errors++;
         $display("FAIL timer_wr_oe: cpu_oe seen at %0d, required never", of);
      end
      checks++;
      if ({sub_we_n, sub_a, sub_di} !== {1'b0, 10'h006, 8'h10}) begin
         errors++;
         $display("FAIL timer_wr_hold: got %b %h %h, required 0 006 10", sub_we_n, sub_a, sub_di);
      end
   endtask

   task automatic test_ram_read();
      int ec, ei, of, ol;
      logic [7:0] di;
      di = 8'($urandom_range(0, 255));
      exp_q.push_back({4'b0100, 1'b1, 10'h025, di});
      rd_q.push_back(RAM_D);
      run_cycle(1'b0, 1'b0, 10'h025, 1'b1, di, 16, ec, ei, of, ol);
      checks++;
      if (ec != 1 || ei != STB_IDX) begin
         errors++;
         $display("FAIL ram_rd_strobe: count %0d at %0d, required 1 at %0d", ec, ei, STB_IDX);
      end
      checks++;
      if (of != OE_IDX || ol != 16 + 2) begin
         errors++;
         $display("FAIL ram_rd_oe: window %0d..%0d, required %0d..%0d", of, ol, OE_IDX, 18);
      end
   endtask

   task automatic test_rom_read();
      int ec, ei, of, ol;
      logic [7:0] di;
      di = 8'($urandom_range(0, 255));
      exp_q.push_back({4'b1000, 1'b1, 10'h3FF, di});
      rd_q.push_back(ROM_D);
      run_cycle(1'b0, 1'b1, 10'h3FF, 1'b1, di, 16, ec, ei, of, ol);
      checks++;
      if (ec != 1 || of != OE_IDX) begin
         errors++;
         $display("FAIL rom_rd: strobes %0d oe at %0d, required 1 and %0d", ec, of, OE_IDX);
      end
      // ROM space wins over the RAM decode bit
      exp_q.push_back({4'b1000, 1'b1, 10'h025, di});
      rd_q.push_back(ROM_D);
      run_cycle(1'b0, 1'b1, 10'h025, 1'b1, di, 16, ec, ei, of, ol);
      checks++;
      if (ec != 1) begin
         errors++;
         $display("FAIL rom_priority: strobes %0d, required 1", ec);
      end
   endtask

   task automatic test_io_timer_read();
      int ec, ei, of, ol;
      exp_q.push_back({4'b0010, 1'b1, 10'h001, 8'h00});
      rd_q.push_back(IO_D);
      run_cycle(1'b0, 1'b0, 10'h041, 1'b1, 8'h00, 16, ec, ei, of, ol);
      checks++;
      if (ec != 1 || cpu_do !== IO_D) begin
         errors++;
         $display("FAIL io_rd: strobes %0d do %h, required 1 %h", ec, cpu_do, IO_D);
      end
      exp_q.push_back({4'b0001, 1'b1, 10'h005, 8'h00});
      rd_q.push_back(TMR_D);
      run_cycle(1'b0, 1'b0, 10'h04D, 1'b1, 8'h00, 16, ec, ei, of, ol);
      checks++;
      if (ec != 1 || cpu_do !== TMR_D) begin
         errors++;
         $display("FAIL timer_rd: strobes %0d do %h, required 1 %h", ec, cpu_do, TMR_D);
      end
   endtask

   task automatic test_deselect();
      int ec, ei, of, ol;
      logic [9:0] a;
      a = 10'($urandom_range(0, 1023));
      run_cycle(1'b1, 1'b1, a, 1'b1, 8'h00, 16, ec, ei, of, ol);
      checks++;
      if (ec != 0 || of != -1) begin
         errors++;
         $display("FAIL deselect: strobes %0d oe at %0d, required 0 and never", ec, of);
      end
   endtask

   task automatic test_short_cycle();
      int ec, ei, of, ol;
      logic [9:0] a;
      logic [7:0] di;
      run_cycle(1'b0, 1'b0, 10'h025, 1'b1, 8'h00, 2, ec, ei, of, ol);
      checks++;
      if (ec != 0 || of != -1 || dbg_state !== IDLE) begin
         errors++;
         $display("FAIL short_cycle: strobes %0d oe %0d state %0d, required 0 never IDLE",
                  ec, of, dbg_state);
      end
      a  = 10'($urandom_range(0, 1023)) & ~10'h040;
      di = 8'($urandom_range(0, 255));
      exp_q.push_back({4'b0100, 1'b1, {4'b0, a[5:0]}, di});
      rd_q.push_back(RAM_D);
      run_cycle(1'b0, 1'b0, a, 1'b1, di, 16, ec, ei, of, ol);
      checks++;
      if (ec != 1 || ei != STB_IDX || of != OE_IDX) begin
         errors++;
         $display("FAIL after_short: strobe %0d at %0d oe %0d, required 1 at %0d oe %0d",
                  ec, ei, of, STB_IDX, OE_IDX);
      end
   endtask

   task automatic test_fall_in_wait();
      int ec, ei, of, ol;
      // phi2 falls while read data is still being waited for
      exp_q.push_back({4'b0010, 1'b1, 10'h000, 8'h00});
      run_cycle(1'b0, 1'b0, 10'h040, 1'b1, 8'h00, 8, ec, ei, of, ol);
      checks++;
      if (ec != 1 || of != -1) begin
         errors++;
         $display("FAIL fall_in_wait_oe: strobes %0d oe at %0d, required 1 and never", ec, of);
      end
      checks++;
      if (cpu_do !== IO_D) begin
         errors++;
         $display("FAIL fall_in_wait_capture: got %h, required %h", cpu_do, IO_D);
      end
   endtask

   task automatic test_back_to_back();
      int ec, ei, of, ol;
      exp_q.push_back({4'b0100, 1'b0, 10'h00A, 8'h77});
      run_cycle(1'b0, 1'b0, 10'h00A, 1'b0, 8'h77, 8, ec, ei, of, ol);
      exp_q.push_back({4'b0001, 1'b1, 10'h004, 8'h00});
      rd_q.push_back(TMR_D);
      run_cycle(1'b0, 1'b0, 10'h04C, 1'b1, 8'h00, 16, ec, ei, of, ol);
      checks++;
      if (ec != 1 || of != OE_IDX || sub_we_n !== 1'b1) begin
         errors++;
         $display("FAIL back_to_back: strobes %0d oe %0d we_n %b, required 1 %0d 1",
                  ec, of, sub_we_n, OE_IDX);
      end
   endtask

   task automatic test_reset_in_wait();
      logic seen;
      seen = 1'b0;
      exp_q.push_back({4'b0100, 1'b1, 10'h011, 8'h00});
      @(negedge clk);
      cs_n = 1'b0; rs = 1'b0; bus_a = 10'h011; bus_rw = 1'b1; bus_di = 8'h00; phi2 = 1'b1;
      for (int n = 0; n < 40; n++) begin
         @(negedge clk);
         if (dbg_state == WAIT) begin
            seen = 1'b1;
            break;
         end
      end
      checks++;
      if (!seen) begin
         errors++;
         $display("FAIL reset_wait_reach: state %0d, required WAIT", dbg_state);
      end
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if ({cpu_oe, rom_en, ram_en, io_en, timer_en, sub_we_n} !== 6'b000001) begin
         errors++;
         $display("FAIL reset_wait_ctrl: got %b, required 000001",
                  {cpu_oe, rom_en, ram_en, io_en, timer_en, sub_we_n});
      end
      checks++;
      if ({cpu_do, sub_a, dbg_state} !== {8'h00, 10'h000, IDLE}) begin
         errors++;
         $display("FAIL reset_wait_data: got do %h a %h state %0d, required 00 000 IDLE",
                  cpu_do, sub_a, dbg_state);
      end
      phi2 = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
   endtask

   initial begin
      test_reset();
      test_timer_write();
      test_ram_read();
      test_rom_read();
      test_io_timer_read();
      test_deselect();
      test_short_cycle();
      test_fall_in_wait();
      test_back_to_back();
      test_reset_in_wait();
      checks++;
      if (exp_q.size() != 0 || rd_q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: %0d strobes %0d reads left, required 0 0",
                  exp_q.size(), rd_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
